// File: rtl/dmem_ctrl_if.sv
// Requester-side bus of the data-memory controller: two ports (0 = LSU, 1 = debug/DMA)
// packed side by side, one bit or field per port.
interface dmem_ctrl_if;
  logic [1:0]       req_i;
  logic [1:0]       we_i;
  logic [1:0][31:0] addr_i;
  logic [1:0][1:0]  size_i;
  logic [1:0]       uns_i;
  logic [1:0][31:0] wdata_i;
  logic [1:0]       gnt_o;
  logic [1:0]       rvalid_o;
  logic [1:0][31:0] rdata_o;
  logic [1:0]       err_o;

  modport master (
    output req_i, we_i, addr_i, size_i, uns_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, size_i, uns_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Two-port round-robin data-memory controller: word accesses to a combinational-read
// memory, sub-word loads by lane extraction, sub-word stores by read-modify-write.
module dmem_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_ctrl_if.slave    bus,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  typedef enum logic [2:0] {IDLE, LD, ST, RMW_RD, RMW_WR} state_t;

  state_t        state_q, state_d;
  logic          ptr_q;
  logic          port_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   wdata_q;
  logic [31:0]   hold_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rvalid_q;
  logic          err_q;

  logic          any_req;
  logic          win;
  logic [31:0]   win_addr;
  logic [1:0]    win_size;
  logic          acc_err;
  logic [1:0]    gnt;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic [31:0]   merged;

  // On a tie the port that did not win last time goes first.
  assign any_req  = |bus.req_i;
  assign win      = (bus.req_i == 2'b11) ? ~ptr_q : bus.req_i[1];
  assign win_addr = bus.addr_i[win];
  assign win_size = bus.size_i[win];
  assign acc_err  = (win_size == 2'b11)
                 || (win_size == 2'b01 && win_addr[0])
                 || (win_size == 2'b10 && win_addr[1:0] != 2'b00)
                 || (win_addr >= ADDR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    gnt       = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt[win] = 1'b1;
          if (acc_err)               state_d = IDLE;
          else if (!bus.we_i[win])   state_d = LD;
          else if (win_size == 2'b10) state_d = ST;
          else                       state_d = RMW_RD;
        end
      end
      LD: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q[AW+1:2];
        state_d   = IDLE;
      end
      ST: begin
        mem_wr_en = 1'b1;
        mem_addr  = addr_q[AW+1:2];
        mem_wdata = wdata_q;
        state_d   = IDLE;
      end
      RMW_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q[AW+1:2];
        state_d   = RMW_WR;
      end
      RMW_WR: begin
        mem_wr_en = 1'b1;
        mem_addr  = addr_q[AW+1:2];
        mem_wdata = hold_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load lane extraction and store lane merge, both from the latched address.
  always_comb begin
    ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:   ld_data = uns_q ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = uns_q ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= 1'b1;
      port_q   <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      hold_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            ptr_q   <= win;
            port_q  <= win;
            addr_q  <= win_addr[AW+1:0];
            size_q  <= win_size;
            uns_q   <= bus.uns_i[win];
            wdata_q <= bus.wdata_i[win];
            if (acc_err) begin
              rvalid_q[win] <= 1'b1;
              err_q         <= 1'b1;
            end
          end
        end
        LD: begin
          rdata_q          <= ld_data;
          rvalid_q[port_q] <= 1'b1;
        end
        ST, RMW_WR: rvalid_q[port_q] <= 1'b1;
        RMW_RD:     hold_q <= merged;
        default: ;
      endcase
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.rvalid_o   = rvalid_q;
  assign bus.err_o      = err_q ? rvalid_q : 2'b00;
  assign bus.rdata_o[0] = rvalid_q[0] ? rdata_q : '0;
  assign bus.rdata_o[1] = rvalid_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized accesses checked against a
// transaction-level memory model.
module tb_dmem_ctrl;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] mem [DEPTH] = '{default: '0};
  logic [31:0] ref_mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;
  bit mon_en = 1'b0;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr_en) begin wr_cnt++; last_wr_addr = mem_addr; end
    if (mem_rd_en) rd_cnt++;
    if (mon_en) begin
      chk("rd_wr_exclusive", 32'(mem_rd_en & mem_wr_en), 32'd0);
      if (!bus.rvalid_o[0]) chk("rdata0_quiet", bus.rdata_o[0], 32'd0);
      if (!bus.rvalid_o[1]) chk("rdata1_quiet", bus.rdata_o[1], 32'd0);
    end
  end

  function automatic bit is_err(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0)
        || (a >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input bit u);
    logic [31:0] w, v;
    w = ref_mem[a / 4];
    if (s == 2'd2) return w;
    if (s == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else begin
      v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (s == 2'd2) begin
      ref_mem[a / 4] = d;
    end else begin
      mask = (s == 2'd0) ? 32'hFF : 32'hFFFF;
      sh   = (s == 2'd0) ? 8 * int'(a % 4) : 16 * int'((a % 4) / 2);
      ref_mem[a / 4] = (ref_mem[a / 4] & ~(mask << sh)) | ((d & mask) << sh);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_rdata0", bus.rdata_o[0], 32'd0);
    chk("rst_rdata1", bus.rdata_o[1], 32'd0);
    chk("rst_mem_en", 32'({mem_rd_en, mem_wr_en}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic drive(input int p, input bit we, input logic [31:0] a, input logic [1:0] s,
                       input bit u, input logic [31:0] d);
    bus.req_i[p]   = 1'b1;
    bus.we_i[p]    = we;
    bus.addr_i[p]  = a;
    bus.size_i[p]  = s;
    bus.uns_i[p]   = u;
    bus.wdata_i[p] = d;
  endtask

  // Single-requester transaction: grant, lockout, latency, result, memory traffic and contents.
  task automatic txn(input int p, input bit we, input logic [31:0] a, input logic [1:0] s,
                     input bit u, input logic [31:0] d);
    bit e, got;
    int lat, n, w0, r0;
    logic [31:0] exp_rd;
    e      = is_err(a, s);
    lat    = e ? 1 : ((we && s != 2'd2) ? 3 : 2);
    exp_rd = (!e && !we) ? ref_load(a, s, u) : 32'd0;
    @(negedge clk);
    drive(p, we, a, s, u, d);
    #1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.gnt_o[p]) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("gnt_seen", 32'(got), 32'd1);
    chk("gnt_vec", 32'(bus.gnt_o), 32'(1 << p));
    w0 = wr_cnt;
    r0 = rd_cnt;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.rvalid_o[p]) chk("lockout_gnt", 32'(bus.gnt_o), 32'd0);
    end while (!bus.rvalid_o[p] && n < 8);
    bus.req_i[p] = 1'b0;
    chk("latency", 32'(n), 32'(lat));
    chk("rvalid_other", 32'(bus.rvalid_o[1-p]), 32'd0);
    chk("err", 32'(bus.err_o[p]), 32'(e));
    chk("rdata", bus.rdata_o[p], exp_rd);
    chk("wr_count", 32'(wr_cnt - w0), 32'(we && !e));
    chk("rd_count", 32'(rd_cnt - r0), 32'(!e && (!we || s != 2'd2)));
    if (we && !e) begin
      ref_store(a, s, d);
      chk("wr_addr", 32'(last_wr_addr), a / 4);
      chk("mem_word", mem[a / 4], ref_mem[a / 4]);
    end
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic [1:0]  rs;
    bit          rwe, ru;
    int          rp;

    foreach (ref_mem[i]) ref_mem[i] = '0;
    bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0;
    bus.size_i = '0; bus.uns_i = '0; bus.wdata_i = '0;

    do_reset();
    mon_en = 1'b1;

    txn(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    chk("sw_deadbeef", mem[4], 32'hDEADBEEF);
    txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    txn(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h0);
    txn(0, 1'b1, 32'h11, 2'd0, 1'b0, 32'hFFFFFFA5);
    chk("sb_a5", mem[4], 32'h0000A500);
    txn(1, 1'b1, 32'h12, 2'd1, 1'b0, 32'h12348001);
    chk("sh_8001", mem[4], 32'h8001A500);
    txn(0, 1'b0, 32'h11, 2'd0, 1'b0, 32'h0);
    txn(1, 1'b0, 32'h11, 2'd0, 1'b1, 32'h0);
    txn(0, 1'b0, 32'h12, 2'd1, 1'b0, 32'h0);

    txn(0, 1'b0, 32'h13, 2'd2, 1'b0, 32'h0);
    txn(1, 1'b0, 32'h01, 2'd1, 1'b0, 32'h0);
    txn(0, 1'b1, 32'h100, 2'd2, 1'b0, 32'h12345678);
    txn(1, 1'b0, 32'h04, 2'd3, 1'b0, 32'h0);
    chk("err_mem_untouched", mem[4], 32'h8001A500);

    // Continuous ties from reset: grants alternate starting with port 0, one per 2 cycles.
    txn(1, 1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D);
    do_reset();
    @(negedge clk);
    drive(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    #1;
    for (int c = 0; c < 12; c++) begin
      int gp, vp;
      gp = (c / 2) % 2;
      vp = ((c / 2) - 1) % 2;
      chk("arb_gnt", 32'(bus.gnt_o), (c % 2 == 0) ? 32'(1 << gp) : 32'd0);
      chk("arb_rvalid", 32'(bus.rvalid_o), (c >= 2 && c % 2 == 0) ? 32'(1 << vp) : 32'd0);
      if (c >= 2 && c % 2 == 0)
        chk("arb_rdata", bus.rdata_o[vp], (vp == 0) ? ref_mem[4] : ref_mem[8]);
      @(negedge clk); #1;
    end
    bus.req_i = '0;
    repeat (2) @(negedge clk);

    // Reset asserted while a byte store sits in its read phase.
    @(negedge clk);
    drive(0, 1'b1, 32'h24, 2'd0, 1'b0, 32'h5A);
    #1 chk("rmw_gnt", 32'(bus.gnt_o), 32'd1);
    @(negedge clk);
    chk("rmw_rd_phase", 32'(mem_rd_en), 32'd1);
    rst_n = 1'b0;
    bus.req_i = '0;
    begin
      int w0;
      w0 = wr_cnt;
      repeat (3) begin
        @(negedge clk);
        chk("rmw_abort_rvalid", 32'(bus.rvalid_o), 32'd0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rmw_abort_nowrite", 32'(wr_cnt - w0), 32'd0);
    end
    chk("rmw_abort_mem", mem[9], ref_mem[9]);
    drive(0, 1'b0, 32'h24, 2'd2, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h28, 2'd2, 1'b0, 32'h0);
    #1 chk("post_rst_gnt", 32'(bus.gnt_o), 32'd1);
    @(negedge clk);
    bus.req_i = '0;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(bus.rvalid_o), 32'd1);
    chk("post_rst_rdata", bus.rdata_o[0], ref_mem[9]);

    // Back-to-back: SB request held through the LW's completion cycle.
    @(negedge clk);
    drive(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    #1 chk("b2b_gnt_lw", 32'(bus.gnt_o), 32'd1);
    @(negedge clk);
    drive(0, 1'b1, 32'h15, 2'd0, 1'b0, 32'h77);
    #1 chk("b2b_lockout", 32'(bus.gnt_o), 32'd0);
    @(negedge clk); #1;
    chk("b2b_lw_rvalid", 32'(bus.rvalid_o), 32'd1);
    chk("b2b_lw_rdata", bus.rdata_o[0], ref_mem[4]);
    chk("b2b_gnt_sb", 32'(bus.gnt_o), 32'd1);
    @(negedge clk);
    bus.req_i = '0;
    chk("b2b_sb_early", 32'(bus.rvalid_o), 32'd0);
    @(negedge clk);
    chk("b2b_sb_early2", 32'(bus.rvalid_o), 32'd0);
    @(negedge clk);
    chk("b2b_sb_rvalid", 32'(bus.rvalid_o), 32'd1);
    ref_store(32'h15, 2'd0, 32'h77);
    chk("b2b_sb_mem", mem[5], ref_mem[5]);

    for (int i = 0; i < 80; i++) begin
      rp  = int'($urandom_range(0, 1));
      rwe = 1'($urandom_range(0, 1));
      ru  = 1'($urandom_range(0, 1));
      rs  = 2'($urandom_range(0, 3));
      if (rs == 2'd3 && $urandom_range(0, 3) != 0) rs = 2'd2;
      rd  = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        ra = 32'($urandom_range(0, 300));
      end else begin
        ra = 32'($urandom_range(0, 63) * 4);
        if (rs == 2'd0)      ra = ra + 32'($urandom_range(0, 3));
        else if (rs == 2'd1) ra = ra + 32'($urandom_range(0, 1) * 2);
      end
      txn(rp, rwe, ra, rs, ru, rd);
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
